// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial add/sub sequencer for an external full-adder cell.
// Define SERIAL_ADD_ABORT_EN to add an abort input that cancels a RUN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADD_ABORT_EN
  input  logic             abort,
`endif
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_cin,
  input  logic             bit_s,
  input  logic             bit_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    count;
  logic             sub_r;
  logic             carry_r;
  logic             cmsb;
  logic             abort_req;

`ifdef SERIAL_ADD_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    bit_a     = 1'b0;
    bit_b     = 1'b0;
    bit_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        bit_a   = a_sh[0];
        bit_b   = b_sh[0] ^ sub_r;
        bit_cin = carry_r;
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (count == LAST) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Subtraction seeds the carry with 1 so the cell computes A + ~B + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      count    <= '0;
      sub_r    <= 1'b0;
      carry_r  <= 1'b0;
      cmsb     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= (state == FIN);
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            sub_r   <= sub;
            carry_r <= sub;
            count   <= '0;
          end
        end
        RUN: begin
          if (abort_req) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_r <= 1'b0;
            count   <= '0;
          end else begin
            res_sh  <= {bit_s, res_sh[WIDTH-1:1]};
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_r <= bit_c;
            count   <= count + CW'(1);
            if (count == LAST) cmsb <= carry_r;
          end
        end
        FIN: begin
          result   <= res_sh;
          cout     <= carry_r;
          overflow <= cmsb ^ carry_r;
          zero     <= (res_sh == '0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: random + directed bench for serial_add_ctrl with an ideal full-adder cell
// and an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bit_a, bit_b, bit_cin, bit_s, bit_c;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] result;
`ifdef SERIAL_ADD_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign bit_s = bit_a ^ bit_b ^ bit_cin;
  assign bit_c = (bit_a & bit_b) | (bit_a & bit_cin) | (bit_b & bit_cin);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef SERIAL_ADD_ABORT_EN
    .abort(abort),
`endif
    .sub(sub),
    .a(a),
    .b(b),
    .bit_a(bit_a),
    .bit_b(bit_b),
    .bit_cin(bit_cin),
    .bit_s(bit_s),
    .bit_c(bit_c),
    .busy(busy),
    .done(done),
    .result(result),
    .cout(cout),
    .overflow(overflow),
    .zero(zero)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // {cout, overflow, zero, result} from plain arithmetic
  function automatic logic [W+2:0] calc(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   f;
    logic [W-1:0] r;
    logic         c, o;
    if (s) begin
      r = x - y;
      c = (x >= y);
      o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      f = {1'b0, x} + {1'b0, y};
      r = f[W-1:0];
      c = f[W];
      o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {c, o, (r == '0), r};
  endfunction

  // {bit_a, bit_b, bit_cin} while bit j is processed
  function automatic logic [2:0] exp_bits(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s, input int j);
    logic [W-1:0]    yy;
    longint unsigned m, c;
    yy = s ? ~y : y;
    m  = (64'd1 << j) - 64'd1;
    c  = ((longint'(x) & m) + (longint'(yy) & m) + longint'(s)) >> j;
    return {x[j], yy[j], c[0]};
  endfunction

  // Reference timeline: ph = edges since the accepting start edge.
  bit           m_act;
  int           m_ph;
  logic [W-1:0] m_a, m_b;
  logic         m_sub;
  logic [W+2:0] m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_ph  <= 0;
      m_out <= '0;
    end else begin
      if (start && (!m_act || m_ph == W + 1)) begin
        m_act <= 1'b1;
        m_ph  <= 0;
        m_a   <= a;
        m_b   <= b;
        m_sub <= sub;
      end
`ifdef SERIAL_ADD_ABORT_EN
      else if (abort && m_act && m_ph <= W - 1) begin
        m_act <= 1'b0;
        m_ph  <= 0;
      end
`endif
      else if (m_act && m_ph == W + 1) begin
        m_act <= 1'b0;
        m_ph  <= 0;
      end else if (m_act) begin
        m_ph <= m_ph + 1;
        if (m_ph == W) m_out <= calc(m_sub, m_a, m_b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic       eb;
      logic [2:0] ebits;
      eb    = m_act && (m_ph <= W - 1);
      ebits = eb ? exp_bits(m_a, m_b, m_sub, m_ph) : 3'b000;
      chk("busy", busy, eb);
      chk("done", done, m_act && (m_ph == W + 1));
      chk("bits", {bit_a, bit_b, bit_cin}, ebits);
      chk("fields", {cout, overflow, zero, result}, m_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ec, input logic eo, input logic ez);
    int lat;
    lat   = 0;
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    for (int i = 1; i <= W + 4 && lat == 0; i++) begin
      tick();
      if (done) lat = i;
    end
    chk("latency", lat, W + 1);
    chk("result", result, er);
    chk("cout", cout, ec);
    chk("overflow", overflow, eo);
    chk("zero", zero, ez);
  endtask

  function automatic logic [W-1:0] pick();
    unique case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 8'h7F;
      3: return 8'h80;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int bc, dc;
    chk("pin_add", calc(1'b0, 8'h7F, 8'h01), {1'b0, 1'b1, 1'b0, 8'h80});
    chk("pin_sub", calc(1'b1, 8'h03, 8'h04), {1'b0, 1'b0, 1'b0, 8'hFF});
    chk("pin_bits", exp_bits(8'h0F, 8'h01, 1'b0, 4), 3'b001);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_fields", {done, cout, overflow, zero, result}, '0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    do_op(1'b0, 8'h25, 8'h1A, 8'h3F, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    do_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    do_op(1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
    do_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    do_op(1'b1, 8'h03, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b0);

    // start re-pulsed mid-RUN must be ignored
    start = 1'b1;
    sub   = 1'b0;
    a     = 8'h25;
    b     = 8'h1A;
    bc    = 0;
    dc    = 0;
    for (int i = 0; i <= 12; i++) begin
      tick();
      start = (i == 2);
      if (i == 2) begin
        a = 8'h01;
        b = 8'h01;
      end
      bc += int'(busy);
      dc += int'(done);
    end
    chk("repulse_busy", bc, W);
    chk("repulse_done", dc, 1);
    chk("repulse_result", result, 8'h3F);

    // reset mid-RUN at count 4
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_fields", {done, cout, overflow, zero, result}, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dc = 0;
    repeat (W + 3) begin
      tick();
      dc += int'(done);
    end
    chk("midrst_nodone", dc, 0);
    do_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);

`ifdef SERIAL_ADD_ABORT_EN
    do_op(1'b0, 8'h25, 8'h1A, 8'h3F, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    a     = 8'h11;
    b     = 8'h22;
    tick();
    start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 8'h3F);
    dc = 0;
    repeat (W + 3) begin
      tick();
      dc += int'(done);
    end
    chk("abort_nodone", dc, 0);
    do_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 3) == 0);
      sub   = 1'($urandom);
      a     = pick();
      b     = pick();
`ifdef SERIAL_ADD_ABORT_EN
      abort = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    start = 1'b0;
`ifdef SERIAL_ADD_ABORT_EN
    abort = 1'b0;
`endif
    repeat (W + 4) tick();
    chk("drain_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
